// File: rtl/turbo_pkg.sv
// Shared types and constants for the turbo deframer: FSM states, block sizes
// and the helper that selects the last data index for the latched block size.
package turbo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int K_SHORT   = 1000;
  localparam int K_LONG    = 6000;
  localparam int TAIL_LEN  = 4;
  localparam int ADDR_W    = 13;
  localparam int GAP_LIMIT = 16;
  localparam int SYM_W     = 3;
  localparam int TIDX_W    = 2;
  localparam int GAP_W     = 5;

  // Index of the final data symbol for the selected block size.
  function automatic logic [ADDR_W-1:0] last_index(input logic long_blk);
    if (long_blk)
      return ADDR_W'(K_LONG - 1);
    else
      return ADDR_W'(K_SHORT - 1);
  endfunction

endpackage

// File: rtl/turbo_tail_capture.sv
// Holds the four 3-bit termination symbols of a frame; the valid flag rises
// when the last slot is written and drops when the next frame starts.
module turbo_tail_capture
  import turbo_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              discard,
  input  logic              wr,
  input  logic [1:0]        idx,
  input  logic [2:0]        sym,
  input  logic              clr_valid,
  output logic [11:0]       tail_bits,
  output logic              tail_valid
);

  logic [TAIL_LEN-1:0][SYM_W-1:0] slots;
  logic                           last_slot;

  assign last_slot = (idx == TIDX_W'(TAIL_LEN - 1));
  assign tail_bits = slots;

  always_ff @(posedge clk) begin
    if (reset || discard) begin
      slots      <= '0;
      tail_valid <= 1'b0;
    end else begin
      if (wr)
        slots[idx] <= sym;
      // Frame start and the final tail write never coincide.
      if (clr_valid)
        tail_valid <= 1'b0;
      else if (wr && last_slot)
        tail_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/turbo_deframer.sv
// Turbo deframer: splits a symbol stream into K data symbols written to the
// decoder buffer plus four captured tail symbols. Optional gap timeout abort
// is enabled by defining TURBO_DEFRAMER_GAP_TIMEOUT_EN.
module turbo_deframer
  import turbo_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sys,
  input  logic        in_par1,
  input  logic        in_par2,
  input  logic        length_flag,
  input  logic        dec_busy,
  output logic        wr_en,
  output logic [12:0] wr_addr,
  output logic [2:0]  wr_data,
  output logic [11:0] tail_bits,
  output logic        tail_valid,
  output logic        frame_done,
  output logic        busy,
  output logic        frame_long,
  output logic        err
);

  state_t              state, state_nxt;
  logic                accept;
  logic                start;
  logic                data_acc;
  logic                tail_acc;
  logic                data_last;
  logic                tail_last;
  logic                abort;
  logic                in_frame;
  logic [SYM_W-1:0]    sym;
  logic [ADDR_W-1:0]   data_cnt;
  logic [TIDX_W-1:0]   tail_cnt;
  logic                vld_p1;
  logic [ADDR_W-1:0]   addr_p1;
  logic [SYM_W-1:0]    data_p1;
  logic                long_q;

  assign sym       = {in_par2, in_par1, in_sys};
  assign accept    = in_valid & in_ready;
  assign in_frame  = (state == DATA) || (state == TAIL);
  assign start     = accept && (state == IDLE);
  assign data_acc  = accept && (state == DATA);
  assign tail_acc  = accept && (state == TAIL);
  assign data_last = data_acc && (data_cnt == last_index(long_q));
  assign tail_last = tail_acc && (tail_cnt == TIDX_W'(TAIL_LEN - 1));

`ifdef TURBO_DEFRAMER_GAP_TIMEOUT_EN
  logic [GAP_W-1:0] gap_cnt;
  logic             err_q;

  // Abort on the GAP_LIMIT-th consecutive empty cycle inside a frame.
  assign abort = in_frame && !in_valid && (gap_cnt == GAP_W'(GAP_LIMIT - 1));
  assign err   = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= abort;
      if (in_frame && !in_valid && !abort)
        gap_cnt <= gap_cnt + GAP_W'(1);
      else
        gap_cnt <= '0;
    end
  end
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = DATA;
      DATA: begin
        if (abort)          state_nxt = IDLE;
        else if (data_last) state_nxt = TAIL;
      end
      TAIL: begin
        if (abort)          state_nxt = IDLE;
        else if (tail_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: in_ready = !dec_busy;
      DATA, TAIL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE:    frame_done = 1'b1;
      default: in_ready = 1'b0;
    endcase
    if (reset)
      in_ready = 1'b0;
  end

  // Symbol counters; data_cnt already points at the next index after start.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_cnt <= '0;
      tail_cnt <= '0;
    end else begin
      if (state == IDLE)
        data_cnt <= start ? ADDR_W'(1) : '0;
      else if (data_acc)
        data_cnt <= data_cnt + ADDR_W'(1);

      if (state != TAIL)
        tail_cnt <= '0;
      else if (tail_acc)
        tail_cnt <= tail_cnt + TIDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      long_q <= 1'b0;
    else if (start)
      long_q <= length_flag;
  end

  assign frame_long = long_q;

  // ---- stage p1: buffer write port, one cycle after the accept ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= start || data_acc;
      if (start || data_acc) begin
        addr_p1 <= start ? '0 : data_cnt;
        data_p1 <= sym;
      end
    end
  end

  assign wr_en   = vld_p1;
  assign wr_addr = addr_p1;
  assign wr_data = data_p1;

  turbo_tail_capture u_tail (
    .clk        (clk),
    .reset      (reset),
    .discard    (abort),
    .wr         (tail_acc),
    .idx        (tail_cnt),
    .sym        (sym),
    .clr_valid  (start),
    .tail_bits  (tail_bits),
    .tail_valid (tail_valid)
  );

endmodule

// File: tb/tb_turbo_deframer.sv
// Randomised bench for turbo_deframer with a frame-position reference model;
// gap-timeout scenarios run when TURBO_DEFRAMER_GAP_TIMEOUT_EN is defined.
module tb_turbo_deframer;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_sys, in_par1, in_par2;
  logic        length_flag, dec_busy;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [2:0]  wr_data;
  logic [11:0] tail_bits;
  logic        tail_valid, frame_done, busy, frame_long, err;

  int errors = 0;
  int checks = 0;

  turbo_deframer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sys(in_sys), .in_par1(in_par1), .in_par2(in_par2),
    .length_flag(length_flag), .dec_busy(dec_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .tail_bits(tail_bits), .tail_valid(tail_valid), .frame_done(frame_done),
    .busy(busy), .frame_long(frame_long), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: frame progress expressed as a count of accepted symbols.
  bit        started = 0;
  bit        m_in_frame, m_done, m_wr_en, m_tvalid, m_flong, m_err;
  int        m_pos, m_K, m_gap;
  bit [12:0] m_wr_addr;
  bit [2:0]  m_wr_data;
  bit [11:0] m_tail;

  function automatic bit model_ready();
    if (m_in_frame) return 1'b1;
    if (m_done)     return 1'b0;
    return !dec_busy;
  endfunction

  always @(posedge clk) begin
    bit       acc;
    bit [2:0] s;
    if (reset) begin
      started = 1; m_in_frame = 0; m_done = 0; m_pos = 0; m_K = 1000; m_gap = 0;
      m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0; m_tail = 0; m_tvalid = 0;
      m_flong = 0; m_err = 0;
    end else if (started) begin
      acc = in_valid && model_ready();
      s = {in_par2, in_par1, in_sys};
      m_wr_en = 0;
      m_err = 0;
      if (m_done) begin
        m_done = 0;
      end else if (!m_in_frame) begin
        if (acc) begin
          m_in_frame = 1; m_pos = 1; m_gap = 0;
          m_K = length_flag ? 6000 : 1000;
          m_flong = length_flag; m_tvalid = 0;
          m_wr_en = 1; m_wr_addr = 0; m_wr_data = s;
        end
      end else if (acc) begin
        m_gap = 0;
        if (m_pos < m_K) begin
          m_wr_en = 1; m_wr_addr = 13'(m_pos); m_wr_data = s;
        end else begin
          m_tail[3*(m_pos-m_K) +: 3] = s;
        end
        m_pos++;
        if (m_pos == m_K + 4) begin
          m_in_frame = 0; m_done = 1; m_tvalid = 1;
        end
      end else begin
`ifdef TURBO_DEFRAMER_GAP_TIMEOUT_EN
        m_gap++;
        if (m_gap == 16) begin
          m_in_frame = 0; m_pos = 0; m_gap = 0; m_err = 1; m_tvalid = 0; m_tail = 0;
        end
`endif
      end
    end
  end

  // Cycle-by-cycle comparison and event counters.
  int        nwr = 0, ndone = 0, nerr = 0;
  logic [12:0] last_addr = '0;

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, reset ? 1'b0 : model_ready());
      chk("wr_en", wr_en, m_wr_en);
      chk("wr_addr", wr_addr, m_wr_addr);
      chk("wr_data", wr_data, m_wr_data);
      chk("tail_bits", tail_bits, m_tail);
      chk("tail_valid", tail_valid, m_tvalid);
      chk("busy", busy, m_in_frame);
      chk("frame_done", frame_done, m_done);
      chk("frame_long", frame_long, m_flong);
      chk("err", err, m_err);
      if (wr_en === 1'b1) begin nwr++; last_addr = wr_addr; end
      if (frame_done === 1'b1) ndone++;
      if (err === 1'b1) nerr++;
    end
  end

  task automatic drive_sym(input logic [2:0] s, input logic lf);
    int guard = 0;
    @(posedge clk); #2;
    in_valid = 1'b1;
    {in_par2, in_par1, in_sys} = s;
    length_flag = lf;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout at %0t: got in_ready=%0b, want 1 within 200 cycles", $time, in_ready);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      in_valid = 1'b0;
      {in_par2, in_par1, in_sys} = 3'($urandom_range(0, 7));
    end
  endtask

  // Sends symbols [first, stop) of a frame (stop<0: the whole frame, then idles the bus).
  task automatic send_frame(input bit lf, input bit [11:0] tail, input int first, input int stop,
                            input int gap_at, input int gap_len, input bit rnd, input int toggle_at);
    int       K = lf ? 6000 : 1000;
    int       last = (stop < 0) ? K + 4 : stop;
    bit [2:0] s;
    bit       l;
    for (int i = first; i < last; i++) begin
      if (i == gap_at) idle(gap_len);
      if (rnd && i > first && $urandom_range(0, 15) == 0) idle($urandom_range(1, 3));
      s = (i >= K) ? tail[3*(i-K) +: 3] : 3'($urandom_range(0, 7));
      if (i == 0) l = lf;
      else if (toggle_at >= 0) l = (i >= toggle_at) ? !lf : lf;
      else l = 1'($urandom_range(0, 1));
      drive_sym(s, l);
    end
    if (stop < 0) idle(1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sys = 0; in_par1 = 0; in_par2 = 0;
    length_flag = 0; dec_busy = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tail_valid", tail_valid, 0);
    @(posedge clk); #2; reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);

    // Short frame, fixed tail.
    nwr = 0; ndone = 0;
    send_frame(0, 12'h39D, 0, -1, -1, 0, 0, -1);
    @(negedge clk);
    chk("f1_done_pulse", frame_done, 1);
    chk("f1_tail_bits", tail_bits, 12'h39D);
    chk("f1_tail_valid", tail_valid, 1);
    @(negedge clk);
    chk("f1_done_low", frame_done, 0);
    chk("f1_tail_hold", tail_valid, 1);
    chk("f1_writes", nwr, 1000);
    chk("f1_last_addr", last_addr, 999);
    chk("f1_dones", ndone, 1);

    // Long frame, length_flag toggled from symbol 3000.
    nwr = 0;
    send_frame(1, 12'hC36, 0, -1, -1, 0, 0, 3000);
    repeat (2) @(negedge clk);
    chk("f2_writes", nwr, 6000);
    chk("f2_last_addr", last_addr, 5999);
    chk("f2_frame_long", frame_long, 1);

    // Seven-cycle pause at data symbol 500.
    nwr = 0;
    send_frame(0, 12'h0F1, 0, -1, 500, 7, 0, -1);
    repeat (2) @(negedge clk);
    chk("f3_writes", nwr, 1000);
    chk("f3_frame_long", frame_long, 0);

    // Decoder busy blocks the frame start.
    nwr = 0;
    idle(3);
    @(posedge clk); #2;
    dec_busy = 1'b1; in_valid = 1'b1; {in_par2, in_par1, in_sys} = 3'b110; length_flag = 0;
    repeat (4) begin
      @(negedge clk);
      chk("busy_block_ready", in_ready, 0);
    end
    @(posedge clk); #2; dec_busy = 1'b0;
    @(negedge clk);
    chk("busy_release_ready", in_ready, 1);
    @(posedge clk); #2; in_valid = 1'b0;
    @(negedge clk);
    chk("busy_first_wr", wr_en, 1);
    chk("busy_first_addr", wr_addr, 0);
    chk("busy_first_data", wr_data, 3'b110);
    send_frame(0, 12'h777, 1, -1, -1, 0, 0, -1);
    repeat (2) @(negedge clk);
    chk("f4_writes", nwr, 1000);

    // Reset while tail symbol 2 is on the bus.
    ndone = 0;
    send_frame(0, 12'hFFF, 0, 1002, -1, 0, 0, -1);
    @(posedge clk); #2;
    reset = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", in_ready, 0);
    @(posedge clk); #2; reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tail_bits", tail_bits, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_done", ndone, 0);
    nwr = 0;
    send_frame(0, 12'h5A3, 0, -1, -1, 0, 0, -1);
    repeat (2) @(negedge clk);
    chk("f5_writes", nwr, 1000);
    chk("f5_tail_bits", tail_bits, 12'h5A3);
    chk("f5_dones", ndone, 1);

    // Random frames with random stalls and random mid-frame length_flag.
    for (int f = 0; f < 4; f++) begin
      @(posedge clk); #2; dec_busy = 1'b1;
      idle($urandom_range(0, 5));
      @(posedge clk); #2; dec_busy = 1'b0;
      send_frame(f == 2, 12'($urandom), 0, -1, -1, 0, 1, -1);
    end

`ifdef TURBO_DEFRAMER_GAP_TIMEOUT_EN
    nerr = 0;
    send_frame(0, 12'h123, 0, 10, -1, 0, 0, -1);
    idle(15);
    send_frame(0, 12'h123, 10, -1, -1, 0, 0, -1);
    repeat (2) @(negedge clk);
    chk("gap15_no_err", nerr, 0);
    send_frame(0, 12'h456, 0, 10, -1, 0, 0, -1);
    idle(16);
    @(posedge clk);
    @(negedge clk);
    chk("gap16_err", err, 1);
    chk("gap16_busy", busy, 0);
    @(negedge clk);
    chk("gap16_err_pulse", err, 0);
    chk("gap16_err_count", nerr, 1);
    send_frame(0, 12'h789, 0, -1, -1, 0, 0, -1);
    repeat (2) @(negedge clk);
`endif

    idle(2);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog at %0t: got no finish, want finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
